staged_control_unit: RTL and testbench
======================================

Name: staged_control_unit

Overview:
- Parametrised, multi-cycle successor to the combinational decode control unit for the single-cycle CPU.
- Owns the instruction-fetch handshake with the instruction cache, registers the decoded control bundle, and stalls on data-cache busywait for lwi/lwd/swi/swd.
- Issues a one-cycle PC_UPDATE pulse when each instruction completes.
- Sits between the PC unit, instruction cache, register file/ALU, and data cache.

Parameters:
- INS_W, 32: instruction width; fields are [OPCODE][DEST][SRC1][SRC2], each INS_W/4 bits.
- REG_COUNT, 8: register-file entries; RADDR_W = $clog2(REG_COUNT).
- PC_W, 32: PC width.
- INS_ADDR_W, 10: instruction-cache address width, taken as PC[INS_ADDR_W-1:0].

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  PC_W  current PC from the PC unit.
- INS_READ  out  1  instruction-cache read request.
- INS_ADDR  out  INS_ADDR_W  instruction-cache address, latched on FETCH entry.
- INS_BUSYWAIT  in  1  instruction cache not ready.
- INSTRUCTION  in  INS_W  instruction word; valid when INS_BUSYWAIT=0.
- DATA_BUSYWAIT  in  1  data cache not ready.
- DEC_VALID  out  1  decoded bundle valid.
- OPCODE  out  INS_W/4  registered opcode.
- READREG1, READREG2, WRITEREG  out  RADDR_W each  low bits of SRC1, SRC2, DEST.
- IMMEDIATE  out  INS_W/4  SRC2 field.
- OFFSET  out  INS_W/4  signed DEST field, used for j/beq.
- ALUOP  out  3  ALU function.
- WRITEENABLE, LOADI_signal, SUB_signal, J_signal, BEQ_signal  out  1 each  control signals.
- READ, WRITE  out  1 each  data-cache request.
- ILLEGAL  out  1  opcode above 11.
- STALL  out  1  CPU must hold state.
- PC_UPDATE  out  1  one-cycle pulse: PC may advance.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; every output is 0 (ALUOP=0, not x).
- FSM states: IDLE, FETCH, EXEC, MEM.
- IDLE: stays one cycle, then FETCH. INS_ADDR is latched from PC on every FETCH entry.
- FETCH:
  - INS_READ=1; STALL=1.
  - At the first posedge with INS_BUSYWAIT=0: register the decoded INSTRUCTION into all bundle outputs, go to EXEC.
  - INS_ADDR holds even if PC changes during FETCH.
- EXEC:
  - DEC_VALID=1 for exactly one cycle.
  - Non-memory opcode or illegal opcode: PC_UPDATE=1 this cycle, next state FETCH.
  - Memory opcode: READ/WRITE=1, STALL=1, next state MEM.
- MEM:
  - DEC_VALID, READ/WRITE and the bundle are held.
  - STALL=1 while DATA_BUSYWAIT=1.
  - First cycle with DATA_BUSYWAIT=0: STALL=0, PC_UPDATE=1, and for loads WRITEENABLE=1 (WRITEENABLE stays 0 in earlier MEM cycles). Next state FETCH, with READ/WRITE/DEC_VALID cleared.
- Decode table, as opcode: ALUOP, then flags that are 1 (all others 0):
  - 0 loadi: 000, WE, LOADI.
  - 1 mov: 000, WE.
  - 2 and: 010, WE.
  - 3 or: 011, WE.
  - 4 add: 001, WE.
  - 5 sub: 001, WE, SUB.
  - 6 j: 000, J.
  - 7 beq: 001, SUB, BEQ.
  - 8 lwi: 000, WE, LOADI, READ.
  - 9 lwd: 000, WE, READ.
  - 10 swi: 000, LOADI, WRITE.
  - 11 swd: 000, WRITE.
  - ≥12: ILLEGAL=1, all enables 0, ALUOP=000; treated as a nop.
- Latency:
  - Non-memory instruction: 2 cycles on an instruction-cache hit; +N cycles per N busywait cycles.
  - Memory instruction: 2 + (cycles in MEM), minimum 3.
- Jump/branch target resolution belongs to the PC unit; this block only flags J/BEQ and pulses PC_UPDATE.
- Boundary conditions:
  - Reset mid-FETCH or mid-MEM: immediate return to IDLE; READ/WRITE/INS_READ drop asynchronously; no PC_UPDATE.
  - INS_BUSYWAIT glitching high in EXEC/MEM: ignored.
  - DATA_BUSYWAIT high outside MEM: ignored.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_LOADI..OP_SWD), ALUOP codes (ALU_FWD=000, ALU_ADD=001, ALU_AND=010, ALU_OR=011), FSM state encoding, control-bundle struct.
- Sub-module opcode_decoder: purely combinational, opcode in → control bundle + ILLEGAL out.
- The top module holds the FSM and the output registers.

Test Plan:
- Reset release, PC=0, INS_BUSYWAIT=0, INSTRUCTION=0x00020005 (loadi r2,5) → IDLE 1 cycle; FETCH INS_ADDR=0; EXEC DEC_VALID=1, WRITEREG=2, IMMEDIATE=5, LOADI=1, WE=1, PC_UPDATE=1; total 3 cycles from release.
- add 0x04030102 with INS_BUSYWAIT high 3 cycles, PC changed to 8 mid-fetch → INS_ADDR stays 0, STALL=1 for 4 cycles, then ALUOP=001, READREG1=1, READREG2=2, WRITEREG=3.
- lwd 0x09040001 with DATA_BUSYWAIT high 4 cycles → READ=1 held for 5 cycles, WE=0 until the last cycle, then WE=1 and PC_UPDATE=1 in the same cycle.
- beq 0x07FE0102 → OFFSET=-2, SUB=1, BEQ=1, ALUOP=001, WE=0; j 0x06030000 → J=1, OFFSET=3.
- Opcode 0x0F → ILLEGAL=1, all enables 0, PC_UPDATE=1 in EXEC.
- swi, then RESET low during MEM → WRITE=0 and every output 0 immediately; IDLE after release; no PC_UPDATE emitted.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, FSM states and control bundle
package cpu_pkg;

  localparam logic [3:0] OP_LOADI = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_LWI   = 4'd8;
  localparam logic [3:0] OP_LWD   = 4'd9;
  localparam logic [3:0] OP_SWI   = 4'd10;
  localparam logic [3:0] OP_SWD   = 4'd11;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_MEM   = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       we;
    logic       loadi;
    logic       sub;
    logic       j;
    logic       beq;
    logic       read;
    logic       write;
    logic       illegal;
  } ctrl_t;

  // Loads and stores are the only instructions that visit the data cache
  function automatic logic is_mem_op(input ctrl_t c);
    return c.read | c.write;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational opcode to control-bundle decode
module opcode_decoder
  import cpu_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  // Table lookup; opcodes past swd decode as an illegal nop with every enable low
  always_comb begin
    ctrl = '0;
    if (opcode > OP_W'(OP_SWD)) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_LOADI: begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; end
        OP_MOV:   begin ctrl.we = 1'b1; end
        OP_AND:   begin ctrl.aluop = ALU_AND; ctrl.we = 1'b1; end
        OP_OR:    begin ctrl.aluop = ALU_OR;  ctrl.we = 1'b1; end
        OP_ADD:   begin ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; end
        OP_SUB:   begin ctrl.aluop = ALU_ADD; ctrl.we = 1'b1; ctrl.sub = 1'b1; end
        OP_J:     begin ctrl.aluop = ALU_FWD; ctrl.j = 1'b1; end
        OP_BEQ:   begin ctrl.aluop = ALU_ADD; ctrl.sub = 1'b1; ctrl.beq = 1'b1; end
        OP_LWI:   begin ctrl.we = 1'b1; ctrl.loadi = 1'b1; ctrl.read = 1'b1; end
        OP_LWD:   begin ctrl.we = 1'b1; ctrl.read = 1'b1; end
        OP_SWI:   begin ctrl.loadi = 1'b1; ctrl.write = 1'b1; end
        OP_SWD:   begin ctrl.write = 1'b1; end
        default:  ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/staged_control_unit.sv
// rtl/staged_control_unit.sv - multi-cycle fetch/decode/memory control FSM
module staged_control_unit
  import cpu_pkg::*;
#(
  parameter int INS_W      = 32,
  parameter int REG_COUNT  = 8,
  parameter int PC_W       = 32,
  parameter int INS_ADDR_W = 10,
  localparam int F_W       = INS_W / 4,
  localparam int RADDR_W   = $clog2(REG_COUNT)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [PC_W-1:0]       PC,
  output logic                  INS_READ,
  output logic [INS_ADDR_W-1:0] INS_ADDR,
  input  logic                  INS_BUSYWAIT,
  input  logic [INS_W-1:0]      INSTRUCTION,
  input  logic                  DATA_BUSYWAIT,
  output logic                  DEC_VALID,
  output logic [F_W-1:0]        OPCODE,
  output logic [RADDR_W-1:0]    READREG1,
  output logic [RADDR_W-1:0]    READREG2,
  output logic [RADDR_W-1:0]    WRITEREG,
  output logic [F_W-1:0]        IMMEDIATE,
  output logic signed [F_W-1:0] OFFSET,
  output logic [2:0]            ALUOP,
  output logic                  WRITEENABLE,
  output logic                  LOADI_signal,
  output logic                  SUB_signal,
  output logic                  J_signal,
  output logic                  BEQ_signal,
  output logic                  READ,
  output logic                  WRITE,
  output logic                  ILLEGAL,
  output logic                  STALL,
  output logic                  PC_UPDATE
);

  logic [F_W-1:0] ins_op, ins_dest, ins_src1, ins_src2;
  ctrl_t          dec_ctrl;
  logic           is_mem_dec, enter_fetch, mem_done;
  logic           unused_ok;

  state_t                state_q, state_d;
  logic [INS_ADDR_W-1:0] ins_addr_q, ins_addr_d;
  logic                  ins_read_q, ins_read_d;
  logic                  stall_q, stall_d;
  logic                  pc_update_q, pc_update_d;
  logic                  dec_valid_q, dec_valid_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [F_W-1:0]        opcode_q, opcode_d;
  logic [F_W-1:0]        dest_q, dest_d;
  logic [RADDR_W-1:0]    src1_q, src1_d;
  logic [F_W-1:0]        src2_q, src2_d;

  assign ins_op    = INSTRUCTION[4*F_W-1 -: F_W];
  assign ins_dest  = INSTRUCTION[3*F_W-1 -: F_W];
  assign ins_src1  = INSTRUCTION[2*F_W-1 -: F_W];
  assign ins_src2  = INSTRUCTION[F_W-1:0];
  assign unused_ok = ^{PC[PC_W-1:INS_ADDR_W], ins_src1[F_W-1:RADDR_W]};

  opcode_decoder #(.OP_W(F_W)) u_decoder (
    .opcode (ins_op),
    .ctrl   (dec_ctrl)
  );

  // Next-state and next-output logic; outputs for a state are prepared on the edge that enters it
  always_comb begin
    state_d     = state_q;
    ins_addr_d  = ins_addr_q;
    ins_read_d  = ins_read_q;
    stall_d     = stall_q;
    pc_update_d = 1'b0;
    dec_valid_d = dec_valid_q;
    ctrl_d      = ctrl_q;
    opcode_d    = opcode_q;
    dest_d      = dest_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    enter_fetch = 1'b0;
    is_mem_dec  = is_mem_op(dec_ctrl);
    case (state_q)
      ST_IDLE: enter_fetch = 1'b1;
      ST_FETCH: begin
        if (!INS_BUSYWAIT) begin
          state_d     = ST_EXEC;
          ins_read_d  = 1'b0;
          dec_valid_d = 1'b1;
          ctrl_d      = dec_ctrl;
          // load write-back waits until the data cache returns
          ctrl_d.we   = dec_ctrl.we & ~is_mem_dec;
          stall_d     = is_mem_dec;
          pc_update_d = ~is_mem_dec;
          opcode_d    = ins_op;
          dest_d      = ins_dest;
          src1_d      = ins_src1[RADDR_W-1:0];
          src2_d      = ins_src2;
        end
      end
      ST_EXEC: begin
        if (is_mem_op(ctrl_q)) state_d = ST_MEM;
        else                   enter_fetch = 1'b1;
      end
      ST_MEM: begin
        if (!DATA_BUSYWAIT) enter_fetch = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_fetch) begin
      state_d     = ST_FETCH;
      ins_addr_d  = PC[INS_ADDR_W-1:0];
      ins_read_d  = 1'b1;
      stall_d     = 1'b1;
      dec_valid_d = 1'b0;
      ctrl_d      = '0;
    end
  end

  // State and output registers, cleared asynchronously so requests drop the moment reset asserts
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      ins_addr_q  <= '0;
      ins_read_q  <= 1'b0;
      stall_q     <= 1'b0;
      pc_update_q <= 1'b0;
      dec_valid_q <= 1'b0;
      ctrl_q      <= '0;
      opcode_q    <= '0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
    end else begin
      state_q     <= state_d;
      ins_addr_q  <= ins_addr_d;
      ins_read_q  <= ins_read_d;
      stall_q     <= stall_d;
      pc_update_q <= pc_update_d;
      dec_valid_q <= dec_valid_d;
      ctrl_q      <= ctrl_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
    end
  end

  // The data cache finishing releases the stall, retires the instruction and fires load write-back in the same cycle
  assign mem_done     = (state_q == ST_MEM) && !DATA_BUSYWAIT;
  assign STALL        = stall_q & ~mem_done;
  assign PC_UPDATE    = pc_update_q | mem_done;
  assign WRITEENABLE  = ctrl_q.we | (mem_done & ctrl_q.read);

  assign INS_READ     = ins_read_q;
  assign INS_ADDR     = ins_addr_q;
  assign DEC_VALID    = dec_valid_q;
  assign OPCODE       = opcode_q;
  assign READREG1     = src1_q;
  assign READREG2     = src2_q[RADDR_W-1:0];
  assign WRITEREG     = dest_q[RADDR_W-1:0];
  assign IMMEDIATE    = src2_q;
  assign OFFSET       = dest_q;
  assign ALUOP        = ctrl_q.aluop;
  assign LOADI_signal = ctrl_q.loadi;
  assign SUB_signal   = ctrl_q.sub;
  assign J_signal     = ctrl_q.j;
  assign BEQ_signal   = ctrl_q.beq;
  assign READ         = ctrl_q.read;
  assign WRITE        = ctrl_q.write;
  assign ILLEGAL      = ctrl_q.illegal;

endmodule

// File: tb/tb_staged_control_unit.sv
// tb/tb_staged_control_unit.sv - randomized scoreboard bench for staged_control_unit
module tb_staged_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC = 32'd0;
  logic        INS_BUSYWAIT = 1'b0;
  logic [31:0] INSTRUCTION = 32'd0;
  logic        DATA_BUSYWAIT = 1'b0;

  logic              INS_READ, DEC_VALID, WRITEENABLE, LOADI_signal, SUB_signal, J_signal;
  logic              BEQ_signal, READ, WRITE, ILLEGAL, STALL, PC_UPDATE;
  logic [9:0]        INS_ADDR;
  logic [7:0]        OPCODE, IMMEDIATE;
  logic signed [7:0] OFFSET;
  logic [2:0]        READREG1, READREG2, WRITEREG, ALUOP;

  always #5 CLK = ~CLK;

  staged_control_unit dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INS_READ(INS_READ), .INS_ADDR(INS_ADDR),
    .INS_BUSYWAIT(INS_BUSYWAIT), .INSTRUCTION(INSTRUCTION), .DATA_BUSYWAIT(DATA_BUSYWAIT),
    .DEC_VALID(DEC_VALID), .OPCODE(OPCODE), .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET), .ALUOP(ALUOP),
    .WRITEENABLE(WRITEENABLE), .LOADI_signal(LOADI_signal), .SUB_signal(SUB_signal),
    .J_signal(J_signal), .BEQ_signal(BEQ_signal), .READ(READ), .WRITE(WRITE),
    .ILLEGAL(ILLEGAL), .STALL(STALL), .PC_UPDATE(PC_UPDATE)
  );

  logic [57:0] all_out;
  assign all_out = {INS_READ, INS_ADDR, DEC_VALID, OPCODE, READREG1, READREG2, WRITEREG,
                    IMMEDIATE, OFFSET, ALUOP, WRITEENABLE, LOADI_signal, SUB_signal, J_signal,
                    BEQ_signal, READ, WRITE, ILLEGAL, STALL, PC_UPDATE};

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dir_ins[$];
  int          dir_nb[$];
  int          dir_nd[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference decode: {aluop, we, loadi, sub, j, beq, read, write, illegal} from per-opcode masks
  function automatic logic [10:0] model_ctrl(input logic [31:0] ins);
    logic [11:0] we_m  = 12'h33F;
    logic [11:0] ld_m  = 12'h501;
    logic [11:0] sub_m = 12'h0A0;
    logic [11:0] j_m   = 12'h040;
    logic [11:0] beq_m = 12'h080;
    logic [11:0] rd_m  = 12'h300;
    logic [11:0] wr_m  = 12'hC00;
    logic [2:0]  alu [12] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    int op = int'(ins[31:24]);
    if (op > 11) return 11'b000_0000_0001;
    return {alu[op], we_m[op], ld_m[op], sub_m[op], j_m[op], beq_m[op], rd_m[op], wr_m[op], 1'b0};
  endfunction

  // Instruction- and data-cache models; inputs change 1 time unit after the rising edge
  initial begin : env
    int          ins_left = 0;
    int          d_left = 0;
    int          pend_nd = 0;
    int          cur_nb = 0;
    bit          f_act = 0;
    bit          d_act = 0;
    logic [31:0] cur_ins = 0;
    logic [9:0]  exp_addr = 0;
    logic [7:0]  op;
    int          mem_cyc;
    exp_t        e;
    forever begin
      @(posedge CLK); #1;
      if (!RESET) begin
        f_act = 0; d_act = 0; INS_BUSYWAIT = 0; DATA_BUSYWAIT = 0;
        continue;
      end
      if (INS_READ) begin
        check("fetch_stall", STALL, 1);
        if (!f_act) begin
          f_act = 1;
          check("ins_addr_latch", INS_ADDR, PC[9:0]);
          exp_addr = PC[9:0];
          PC = $urandom();
          if (dir_ins.size() > 0) begin
            cur_ins = dir_ins.pop_front();
            cur_nb  = dir_nb.pop_front();
            pend_nd = dir_nd.pop_front();
          end else begin
            op      = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 12));
            cur_ins = {op, 24'($urandom())};
            cur_nb  = $urandom_range(0, 3);
            pend_nd = $urandom_range(0, 4);
          end
          mem_cyc  = (cur_ins[31:24] >= 8 && cur_ins[31:24] <= 11) ? ((pend_nd > 1) ? pend_nd : 1) : 0;
          e.ins    = cur_ins;
          e.cycles = 32'(cur_nb + 2 + mem_cyc);
          exp_q.push_back(e);
          ins_left = cur_nb;
        end else begin
          check("ins_addr_hold", INS_ADDR, exp_addr);
        end
        if (ins_left > 0) begin
          INS_BUSYWAIT = 1; INSTRUCTION = $urandom(); ins_left--;
        end else begin
          INS_BUSYWAIT = 0; INSTRUCTION = cur_ins;
        end
      end else begin
        f_act = 0;
        INS_BUSYWAIT = ($urandom_range(0, 3) == 0);
        INSTRUCTION = $urandom();
      end
      if (READ || WRITE) begin
        if (!d_act) begin
          d_act = 1; d_left = pend_nd;
        end else if (d_left > 0) begin
          d_left--;
        end
        DATA_BUSYWAIT = (d_left > 0);
      end else begin
        d_act = 0;
        DATA_BUSYWAIT = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: retire instructions on PC_UPDATE against the scoreboard, police the other cycles
  initial begin : mon
    bit   prev_ir = 0;
    int   cnt = 0;
    int   off;
    int   act_off;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        prev_ir = 0; cnt = 0;
        continue;
      end
      if (INS_READ && !prev_ir) cnt = 1;
      else                      cnt++;
      prev_ir = INS_READ;
      if (!DEC_VALID) begin
        check("quiet_no_dec", {PC_UPDATE, READ, WRITE, WRITEENABLE}, 4'b0000);
      end else if (!PC_UPDATE) begin
        check("mem_wait", {STALL, WRITEENABLE, READ | WRITE}, 3'b101);
      end else if (exp_q.size() == 0) begin
        check("pc_update_unexpected", PC_UPDATE, 0);
      end else begin
        e = exp_q.pop_front();
        check("ctrl", {ALUOP, WRITEENABLE, LOADI_signal, SUB_signal, J_signal, BEQ_signal,
                       READ, WRITE, ILLEGAL}, model_ctrl(e.ins));
        check("fields", {OPCODE, WRITEREG, READREG1, READREG2, IMMEDIATE},
              {e.ins[31:24], e.ins[18:16], e.ins[10:8], e.ins[2:0], e.ins[7:0]});
        off = int'(e.ins[23:16]);
        if (off > 127) off = off - 256;
        act_off = OFFSET;
        check("offset", 64'(act_off), 64'(off));
        check("latency", cnt, e.cycles);
        check("stall_at_done", STALL, 0);
        done_cnt++;
      end
    end
  end

  initial begin : main
    int target;
    dir_ins.push_back(32'h00020005); dir_nb.push_back(0); dir_nd.push_back(0);
    dir_ins.push_back(32'h04030102); dir_nb.push_back(3); dir_nd.push_back(0);
    dir_ins.push_back(32'h09040001); dir_nb.push_back(0); dir_nd.push_back(4);
    dir_ins.push_back(32'h07FE0102); dir_nb.push_back(1); dir_nd.push_back(0);
    dir_ins.push_back(32'h06030000); dir_nb.push_back(0); dir_nd.push_back(0);
    dir_ins.push_back(32'h0F000000); dir_nb.push_back(0); dir_nd.push_back(0);
    dir_ins.push_back(32'h080500AA); dir_nb.push_back(2); dir_nd.push_back(0);
    dir_ins.push_back(32'h0B010203); dir_nb.push_back(0); dir_nd.push_back(1);

    RESET = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", all_out, 0);
    @(negedge CLK);
    RESET = 1;
    #1;
    check("idle_first", INS_READ, 0);

    for (int i = 0; i < 5000 && done_cnt < 80; i++) @(posedge CLK);
    check("random_phase_done", done_cnt >= 80, 1);

    dir_ins.push_back(32'h0A010203); dir_nb.push_back(0); dir_nd.push_back(20);
    for (int i = 0; i < 200 && dir_ins.size() != 0; i++) @(posedge CLK);
    for (int i = 0; i < 50 && !WRITE; i++) begin
      @(posedge CLK); #2;
    end
    repeat (2) @(posedge CLK);
    #3;
    check("swi_in_mem", {WRITE, STALL, PC_UPDATE}, 3'b110);
    RESET = 0;
    exp_q.delete();
    #1;
    check("reset_mid_mem", all_out, 0);
    repeat (2) @(posedge CLK);
    #3;
    check("reset_hold", all_out, 0);
    RESET = 1;
    #1;
    check("idle_after_release", INS_READ, 0);
    @(posedge CLK);
    #2;
    check("fetch_after_idle", INS_READ, 1);

    target = done_cnt + 10;
    for (int i = 0; i < 1000 && done_cnt < target; i++) @(posedge CLK);
    check("post_reset_done", done_cnt >= target, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
